fpa_sched: RTL
==============

FPA_SCHED -- requirements
Module: fpa_sched

Interface
REQ-001 Parameter: LAT, default 3, cycles from operands presented on fpa_a/fpa_b to a valid result on fpa_c.
REQ-002 Parameter: RDEPTH, default 2, result FIFO depth per requester and per-requester credit limit.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: req_valid[i]  in  1  requester i (i=0,1) has an operation pending.
REQ-007 Port: req_ready[i]  out  1  requester i is granted this cycle.
REQ-008 Port: req_a[i], req_b[i]  in  32  IEEE-754 single-precision operands.
REQ-009 Port: req_sub[i]  in  1  1 = a-b, 0 = a+b.
REQ-010 Port: fpa_a, fpa_b  out  32  operands to the shared adder.
REQ-011 Port: fpa_c  in  32  adder result.
REQ-012 Port: res_valid[i]  out  1  requester i's FIFO head is valid.
REQ-013 Port: res_data[i]  out  32  requester i's FIFO head.
REQ-014 Port: res_ack[i]  in  1  pops requester i's FIFO head when res_valid[i]=1.
REQ-015 Port: busy  out  1  any operation in flight, or any result FIFO non-empty.

Function
REQ-016 Issue and handshake:
- An operation issues on an edge where req_valid[i] and req_ready[i] are both 1.
- At most one issue occurs per cycle.
- req_ready[i] is combinational on req_valid, credits and the RR pointer.
- req_ready[i] is never 1 while req_valid[i]=0.
REQ-017 Arbitration (round-robin):
- A requester is eligible when req_valid[i]=1 and credit[i]>0.
- One eligible requester: it wins.
- Both eligible: the requester opposite rr_last wins.
- rr_last updates to the winner on each issue; it holds when nothing issues.
REQ-018 Credits:
- credit[i] = RDEPTH - (in-flight ops of i + entries in FIFO i).
- Range is 0..RDEPTH.
- Decrement on issue, increment on pop.
- Simultaneous issue and pop of the same requester leave the credit unchanged.
- A result FIFO write can therefore never overflow.
REQ-019 Operand drive:
- On issue, fpa_a<=req_a and fpa_b<=req_b are registered.
- When req_sub=1, fpa_b takes req_b with bit 31 inverted.
- With no issue, fpa_a/fpa_b hold their previous values.
REQ-020 Tag pipeline:
- An LAT-stage shift register carries {valid, owner} per issue.
- An issue at edge E has its tag exit at edge E+1+LAT.
- On that edge, fpa_c is written into FIFO[owner].
REQ-021 Result FIFOs:
- One FIFO per requester, RDEPTH deep, with independent wrap-around read/write pointers.
- res_valid rises the cycle after the write.
- Pop on res_ack & res_valid; res_ack while empty is ignored.
- A simultaneous write and pop on the same FIFO keeps the count and preserves order.
REQ-022 Ordering: results per requester return in issue order; no ordering holds across requesters.
REQ-023 Throughput: sustained one issue per cycle when credits allow; the adder pipeline is never stalled by this block.

Reset
REQ-024 While rst=1 at an edge, the following are cleared: tag pipeline valids, FIFO pointers and counts, credits to RDEPTH, rr_last to 1 (requester 0 wins the first tie), fpa_a=fpa_b=0.
REQ-025 Outputs during and after reset: req_ready=0 while rst=1; res_valid=0 and busy=0 after the reset edge.
REQ-026 Reset mid-operation: in-flight operations are discarded, and their results are never written to any FIFO.

Verification
REQ-027 Single op: req_valid[0]=1, a=0x3F800000, b=0x40000000, sub=0, adder model returns 0x40400000 -> fpa_a/b shown the cycle after issue; res_valid[0]=1 with 0x40400000 at edge E+LAT+2 (E = issue edge).
REQ-028 Subtract: req_sub[1]=1, b=0x40000000 -> fpa_b=0xC0000000.
REQ-029 Contention: both requesters valid continuously, acks always 1 -> grants alternate 0,1,0,1...; first grant goes to 0 after reset.
REQ-030 Credit stall: requester 0 valid, res_ack[0]=0 -> exactly RDEPTH=2 issues, then req_ready[0]=0 while requester 1 still issues; one ack -> exactly one further issue for requester 0.
REQ-031 Simultaneous events: FIFO write and ack on the same edge with count 1 -> count stays 1 and the head advances to the newer result in order.
REQ-032 Reset mid-flight: assert rst one cycle after issue -> no res_valid ever appears for that op; busy=0 and credits=RDEPTH afterward.

Source files
------------

// File: rtl/fpa_sched.sv
// rtl/fpa_sched.sv - two-requester round-robin scheduler for a shared pipelined FP adder
module fpa_sched #(
  parameter int LAT    = 3,
  parameter int RDEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic [1:0]       req_sub,
  output logic [31:0]      fpa_a,
  output logic [31:0]      fpa_b,
  input  logic [31:0]      fpa_c,
  output logic [1:0]       res_valid,
  output logic [1:0][31:0] res_data,
  input  logic [1:0]       res_ack,
  output logic             busy
);

  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = $clog2(RDEPTH + 1);
  localparam logic [PW-1:0] LastPtr = PW'(RDEPTH - 1);
  localparam logic [CW-1:0] FullCredit = CW'(RDEPTH);

  logic [1:0][CW-1:0] credit;
  logic               rrLast;
  logic [LAT:0]       tagValid;
  logic [LAT:0]       tagOwner;
  logic [31:0]        fifoMem [2][RDEPTH];
  logic [1:0][PW-1:0] wrPtr;
  logic [1:0][PW-1:0] rdPtr;
  logic [1:0][CW-1:0] count;

  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] push;
  logic [1:0] pop;
  logic       issue;
  logic       winner;

  // Round-robin grant among requesters that are valid and still hold a credit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = req_valid[i] && (credit[i] != '0) && !rst;
    end
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = rrLast ? 2'b01 : 2'b10;
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign winner    = grant[1];

  // Result-side strobes: tag leaving the pipe writes its owner's FIFO, ack pops a non-empty head.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 2; i++) begin
      push[i] = tagValid[LAT] && (tagOwner[LAT] == i[0]);
      pop[i]  = res_ack[i] && (count[i] != '0);
    end
  end

  // Remember the last winner so the other requester wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrLast <= 1'b1;
    end else if (issue) begin
      rrLast <= winner;
    end
  end

  // Register operands for the adder; subtraction flips the sign of b.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpa_a <= '0;
      fpa_b <= '0;
    end else if (issue) begin
      fpa_a <= req_a[winner];
      fpa_b <= req_b[winner] ^ {req_sub[winner], 31'b0};
    end
  end

  // Tag shift register tracks who owns each adder stage; stage LAT lines up with fpa_c.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid <= '0;
      tagOwner <= '0;
    end else begin
      tagValid <= {tagValid[LAT-1:0], issue};
      tagOwner <= {tagOwner[LAT-1:0], winner};
    end
  end

  // Credits cover in-flight ops plus queued results, so a FIFO write always has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        credit[i] <= FullCredit;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        credit[i] <= credit[i] - CW'(grant[i]) + CW'(pop[i]);
      end
    end
  end

  // FIFO pointers and occupancy; push and pop on the same edge keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wrPtr[i] <= (wrPtr[i] == LastPtr) ? '0 : wrPtr[i] + 1'b1;
        end
        if (pop[i]) begin
          rdPtr[i] <= (rdPtr[i] == LastPtr) ? '0 : rdPtr[i] + 1'b1;
        end
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // FIFO storage has no reset; validity comes from the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i] && !rst) begin
        fifoMem[i][wrPtr[i]] <= fpa_c;
      end
    end
  end

  // Present each FIFO head and its valid flag.
  always_comb begin
    res_data  = '0;
    res_valid = '0;
    for (int i = 0; i < 2; i++) begin
      res_data[i]  = fifoMem[i][rdPtr[i]];
      res_valid[i] = (count[i] != '0);
    end
  end

  assign busy = (|tagValid) || (count[0] != '0) || (count[1] != '0);

endmodule
